// File: rtl/edge_output_writer.sv
// Memory-side writer for the 9-sum result buffer: one valid/ready write per
// request, frame word counting, overrun and timeout error flags.
module edge_output_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_WORDS = 9,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_frame_start,
    input  logic        i_write_enable,
    input  logic [31:0] i_write_data,
    output logic        o_write_complete,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    output logic        o_frame_done,
    output logic        o_overrun,
    output logic        o_timeout_err
);

    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_base;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          mem_write_q, mem_write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          complete_q, complete_d;
    logic          frame_done_q, frame_done_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          finish;

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        mem_write_d  = mem_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        timeout_d    = timeout_q;
        complete_d   = 1'b0;
        frame_done_d = 1'b0;
        // frame_start clears first so a same-edge request or completion
        // sees a fresh frame
        cnt_base     = i_frame_start ? '0 : cnt_q;
        cnt_d        = cnt_base;
        overrun_d    = i_frame_start ? 1'b0 : overrun_q;
        finish       = i_mem_ready || (tcnt_q == TW'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                if (i_write_enable) begin
                    wdata_d     = i_write_data;
                    addr_d      = BASE_ADDR + (32'(cnt_base) << 2);
                    mem_write_d = 1'b1;
                    tcnt_d      = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (i_write_enable) overrun_d = 1'b1;
                if (finish) begin
                    mem_write_d = 1'b0;
                    complete_d  = 1'b1;
                    tcnt_d      = '0;
                    state_d     = DONE;
                    if (!i_mem_ready) timeout_d = 1'b1;
                    if (!i_frame_start) begin
                        if (cnt_q == CW'(NUM_WORDS - 1)) begin
                            cnt_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DONE: begin
                if (i_write_enable) overrun_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            complete_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            mem_write_q  <= mem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            complete_q   <= complete_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_write_complete = complete_q;
    assign o_mem_write      = mem_write_q;
    assign o_mem_addr       = addr_q;
    assign o_mem_wdata      = wdata_q;
    assign o_frame_done     = frame_done_q;
    assign o_overrun        = overrun_q;
    assign o_timeout_err    = timeout_q;

endmodule

// File: tb/tb_edge_output_writer.sv
// Directed bench for edge_output_writer: frame addressing, ready stalls,
// timeout abandon, overrun, frame restart and mid-write reset.
module tb_edge_output_writer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        i_frame_start = 1'b0;
    logic        i_write_enable = 1'b0;
    logic [31:0] i_write_data = '0;
    logic        i_mem_ready = 1'b0;
    logic        o_write_complete;
    logic        o_mem_write;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_frame_done;
    logic        o_overrun;
    logic        o_timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    edge_output_writer dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_frame_start    (i_frame_start),
        .i_write_enable   (i_write_enable),
        .i_write_data     (i_write_data),
        .o_write_complete (o_write_complete),
        .o_mem_write      (o_mem_write),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wdata      (o_mem_wdata),
        .i_mem_ready      (i_mem_ready),
        .o_frame_done     (o_frame_done),
        .o_overrun        (o_overrun),
        .o_timeout_err    (o_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, ".wr"}, 32'(o_mem_write), 0);
        check({tag, ".cmp"}, 32'(o_write_complete), 0);
        check({tag, ".fd"}, 32'(o_frame_done), 0);
    endtask

    // one write with ready high, requests 4 cycles apart
    task automatic do_word(input logic [31:0] data, input logic [31:0] addr,
                           input logic fd, input logic fs);
        i_write_enable = 1'b1;
        i_write_data   = data;
        i_frame_start  = fs;
        tick();
        i_write_enable = 1'b0;
        i_frame_start  = 1'b0;
        check("w.wr", 32'(o_mem_write), 1);
        check("w.addr", o_mem_addr, addr);
        check("w.data", o_mem_wdata, data);
        check("w.cmp0", 32'(o_write_complete), 0);
        tick();
        check("w.cmp", 32'(o_write_complete), 1);
        check("w.fd", 32'(o_frame_done), 32'(fd));
        check("w.wr0", 32'(o_mem_write), 0);
        tick();
        check("w.cmpdrop", 32'(o_write_complete), 0);
        check("w.fddrop", 32'(o_frame_done), 0);
        tick();
    endtask

    initial begin
        tick();
        check_idle_outs("rst");
        check("rst.addr", o_mem_addr, 0);
        check("rst.data", o_mem_wdata, 0);
        check("rst.ovr", 32'(o_overrun), 0);
        check("rst.to", 32'(o_timeout_err), 0);
        n_rst = 1'b1;
        tick();

        // full frame with immediate ready
        i_mem_ready = 1'b1;
        for (int i = 0; i < 9; i++)
            do_word(32'h1111_1111 * (i + 1), 32'(4 * i), i == 8, 1'b0);

        // five stalled cycles, then ready
        i_mem_ready    = 1'b0;
        i_write_enable = 1'b1;
        i_write_data   = 32'hCAFE_0001;
        tick();
        i_write_enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("st.wr", 32'(o_mem_write), 1);
            check("st.addr", o_mem_addr, 32'h0);
            check("st.data", o_mem_wdata, 32'hCAFE_0001);
            check("st.cmp0", 32'(o_write_complete), 0);
            if (k == 5) i_mem_ready = 1'b1;
            tick();
        end
        check("st.cmp", 32'(o_write_complete), 1);
        check("st.wr0", 32'(o_mem_write), 0);
        check("st.to", 32'(o_timeout_err), 0);
        tick();
        check("st.cmpdrop", 32'(o_write_complete), 0);

        // never ready: abandoned after 16 issue cycles
        i_mem_ready    = 1'b0;
        i_write_enable = 1'b1;
        i_write_data   = 32'hDEAD_0002;
        tick();
        i_write_enable = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("to.wr", 32'(o_mem_write), 1);
            check("to.cmp0", 32'(o_write_complete), 0);
            tick();
        end
        check("to.addr", o_mem_addr, 32'h4);
        check("to.wr0", 32'(o_mem_write), 0);
        check("to.cmp", 32'(o_write_complete), 1);
        check("to.err", 32'(o_timeout_err), 1);
        tick();
        check("to.cmpdrop", 32'(o_write_complete), 0);
        i_mem_ready = 1'b1;
        do_word(32'hBEEF_0003, 32'h8, 1'b0, 1'b0);
        check("to.sticky", 32'(o_timeout_err), 1);

        // second request while ISSUE
        i_write_enable = 1'b1;
        i_write_data   = 32'hAAAA_0004;
        tick();
        i_write_data   = 32'h5555_9999;
        check("ov.addr", o_mem_addr, 32'hC);
        tick();
        i_write_enable = 1'b0;
        check("ov.flag", 32'(o_overrun), 1);
        check("ov.cmp", 32'(o_write_complete), 1);
        check("ov.data", o_mem_wdata, 32'hAAAA_0004);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ov.single", 32'(o_write_complete), 0);
            check("ov.wr0", 32'(o_mem_write), 0);
            check("ov.data2", o_mem_wdata, 32'hAAAA_0004);
        end

        // fifth word, then restart frame with a request
        do_word(32'h0000_0005, 32'h10, 1'b0, 1'b0);
        check("fs.ovr_pre", 32'(o_overrun), 1);
        for (int i = 0; i < 9; i++) begin
            do_word(32'h7000_0000 + 32'(i), 32'(4 * i), i == 8, i == 0);
            if (i == 0) check("fs.ovr", 32'(o_overrun), 0);
        end

        // reset in the middle of a write
        do_word(32'h0000_00A0, 32'h0, 1'b0, 1'b0);
        i_mem_ready    = 1'b0;
        i_write_enable = 1'b1;
        i_write_data   = 32'h0000_00A1;
        tick();
        i_write_enable = 1'b0;
        check("mr.wr", 32'(o_mem_write), 1);
        check("mr.addr", o_mem_addr, 32'h4);
        #2;
        n_rst = 1'b0;
        #1;
        check_idle_outs("mr");
        check("mr.addr0", o_mem_addr, 0);
        check("mr.data0", o_mem_wdata, 0);
        check("mr.to", 32'(o_timeout_err), 0);
        tick();
        check("mr.cmp", 32'(o_write_complete), 0);
        n_rst = 1'b1;
        tick();
        i_mem_ready = 1'b1;
        do_word(32'h0000_00A2, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_output_writer.md
Name: edge_output_writer

Overview:
- Downstream neighbour of the 9-sum result buffer. Each one-cycle write request carries one 32-bit replicated-pixel word.
- Computes the destination address and performs one write on the memory-side interface, which uses a valid/ready handshake.
- Returns a one-cycle completion pulse so the buffer can advance to its next word.
- Tracks the word count per output frame and flags protocol and memory errors.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0 of the output frame
- NUM_WORDS, 9, words per frame; the address counter wraps after this many
- TIMEOUT, 16, maximum cycles o_mem_write may stay high without i_mem_ready before the write is abandoned

Ports:
- clk  in  1  clock
- n_rst  in  1  reset
- i_frame_start  in  1  synchronous clear of the word counter, frame_done and overrun
- i_write_enable  in  1  one-cycle write request from the upstream buffer
- i_write_data  in  32  word to write; valid in the cycle i_write_enable is high
- o_write_complete  out  1  one-cycle pulse; the current request is finished
- o_mem_write  out  1  memory write valid
- o_mem_addr  out  32  memory byte address
- o_mem_wdata  out  32  memory write data
- i_mem_ready  in  1  memory accepts the write in a cycle where o_mem_write=1
- o_frame_done  out  1  one-cycle pulse when the last word of a frame completes
- o_overrun  out  1  sticky; a request arrived while busy
- o_timeout_err  out  1  sticky; a write was abandoned after TIMEOUT cycles

Behaviour:
- Clock and reset: clk, rising edge. Reset is n_rst, asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; word counter 0; timeout counter 0.
- All outputs are registered.
- Ready handshake on the memory side uses i_mem_ready.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - i_write_enable=1 at an edge latches i_write_data into o_mem_wdata.
  - o_mem_addr = BASE_ADDR + 4*count, 32-bit modulo.
  - o_mem_write becomes 1 and the state moves to ISSUE.
- ISSUE:
  - o_mem_write, o_mem_addr and o_mem_wdata are held stable.
  - Edge with i_mem_ready=1: o_mem_write becomes 0, o_write_complete becomes 1, the state moves to DONE, and the counter increments.
  - If count was NUM_WORDS-1, the counter wraps to 0 and o_frame_done pulses together with o_write_complete.
  - Timeout counter increments each ISSUE cycle without ready. When it reaches TIMEOUT-1 and ready is still 0, the write is abandoned:
    - o_mem_write becomes 0;
    - o_timeout_err is set;
    - o_write_complete still pulses, so upstream never deadlocks;
    - the counter still advances.
  - Timeout counter clears on leaving ISSUE.
- DONE:
  - One cycle; o_write_complete=1, then the state returns to IDLE and the pulse drops.
  - The next request is accepted from the following edge onward.
- Latency with immediate ready: i_write_enable in cycle 0, o_mem_write in cycle 1, o_write_complete in cycle 2. Minimum 3 cycles per word.
- i_write_enable=1 in ISSUE or DONE: the request is ignored (no data latch) and o_overrun is set.
- i_frame_start=1:
  - Counter is cleared to 0; o_frame_done and o_overrun are cleared. o_timeout_err is cleared only by reset.
  - An in-flight write completes with its already latched address.
  - If a completion increment happens in the same edge, frame_start wins (counter=0, no frame_done pulse).
- i_frame_start and i_write_enable together in IDLE: counter clears first; the write uses count 0 (address BASE_ADDR).
- Reset mid-write: o_mem_write drops immediately; no completion pulse.
- i_mem_ready while o_mem_write=0 is ignored.

Test Plan:
- Reset release, i_mem_ready tied 1, requests 0x11111111…0x99999999 spaced 4 cycles apart:
  - nine writes to addresses 0x00,0x04,…,0x20 with matching data;
  - o_write_complete 2 cycles after each request;
  - o_frame_done coincides with the 9th completion.
- i_mem_ready held 0 for 5 cycles then 1:
  - o_mem_write high 6 cycles with stable addr/data;
  - one completion pulse; o_timeout_err stays 0.
- i_mem_ready held 0, TIMEOUT=16:
  - write abandoned after 16 ISSUE cycles;
  - o_timeout_err=1, o_write_complete pulses, next address still advances by 4.
- Request one cycle after an accepted request (state ISSUE):
  - o_overrun=1, second data never appears on o_mem_wdata, only one completion.
- After 5 words, i_frame_start pulsed together with a new request:
  - that write goes to BASE_ADDR; o_overrun cleared; frame_done occurs only after 9 further words.
- n_rst asserted while o_mem_write=1:
  - all outputs 0 immediately;
  - after release, the first request writes to BASE_ADDR.
